complex_div: RTL and testbench

COMPLEX_DIV -- requirements
Module: complex_div

---
 rtl/complex_div_if.sv | 9 +
 rtl/complex_div.sv | 117 +++++++++++
 tb/tb_complex_div.sv | 129 ++++++++++++
 3 files changed

// File: rtl/complex_div_if.sv
// complex_div_if: operand, handshake and result signals of the complex divider
interface complex_div_if;
    logic [15:0] a, b, c, d;
    logic        start, busy, done;
    logic [15:0] R, J;
    logic        over_d, div0;
    modport slave (input a, b, c, d, start, output busy, done, R, J, over_d, div0);
    modport master (output a, b, c, d, start, input busy, done, R, J, over_d, div0);
endinterface

// File: rtl/complex_div.sv
// complex_div: Q7.8 complex division (a+bi)/(c+di) via two parallel restoring dividers
module complex_div (
    input logic         clk,
    input logic         rstn,
    complex_div_if.slave io
);
    typedef enum logic [2:0] {IDLE, MUL, PREP, DIV, DONE} state_t;
    state_t state;
    logic signed [15:0] ar, br, cr, dr;
    logic signed [32:0] nr, ni;
    logic [31:0] den, rem_r, rem_i;
    logic [15:0] low_r, low_i, q_r, q_i, r_out, j_out;
    logic [3:0]  cnt;
    logic sr, si, ovr, ovi, busy, done, over_d, div0;
    logic signed [31:0] ac, bd, bc, ad, cc, dd;
    logic signed [32:0] nr_c, ni_c;
    logic [31:0] den_c, mag_r, mag_i;
    logic [32:0] st_r, st_i;
    assign ac = ar * cr;
    assign bd = br * dr;
    assign bc = br * cr;
    assign ad = ar * dr;
    assign cc = cr * cr;
    assign dd = dr * dr;
    assign nr_c = 33'(ac) + 33'(bd);
    assign ni_c = 33'(bc) - 33'(ad);
    assign den_c = cc + dd;
    assign mag_r = nr[32] ? 32'(-nr) : nr[31:0];
    assign mag_i = ni[32] ? 32'(-ni) : ni[31:0];
    // One restoring step: shift in the next dividend bit, subtract when it fits
    function automatic logic [32:0] step(input logic [31:0] rem, input logic nb, input logic [31:0] dv);
        logic [32:0] t;
        t = {rem, nb};
        return t >= {1'b0, dv} ? {1'b1, 32'(t - {1'b0, dv})} : {1'b0, t[31:0]};
    endfunction
    function automatic logic [15:0] fin(input logic ov, input logic s, input logic [15:0] q);
        return ov ? (s ? 16'h8000 : 16'h7fff) : (s ? 16'(-q) : q);
    endfunction
    assign st_r = step(rem_r, low_r[15], den);
    assign st_i = step(rem_i, low_i[15], den);
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
            {ar, br, cr, dr} <= '0;
            {nr, ni, den} <= '0;
            {rem_r, rem_i, low_r, low_i, q_r, q_i, cnt} <= '0;
            {sr, si, ovr, ovi} <= '0;
            {r_out, j_out, busy, done, over_d, div0} <= '0;
        end else begin
            case (state)
                IDLE: if (io.start) begin
                    ar <= io.a;
                    br <= io.b;
                    cr <= io.c;
                    dr <= io.d;
                    busy <= 1'b1;
                    state <= MUL;
                end
                MUL: begin
                    nr <= nr_c;
                    ni <= ni_c;
                    den <= den_c;
                    state <= PREP;
                end
                PREP: begin
                    sr <= nr[32];
                    si <= ni[32];
                    ovr <= {8'b0, mag_r} >= {1'b0, den, 7'b0};
                    ovi <= {8'b0, mag_i} >= {1'b0, den, 7'b0};
                    // Quotient < 2^16, so the top 24 dividend bits seed the remainder
                    rem_r <= {8'b0, mag_r[31:8]};
                    rem_i <= {8'b0, mag_i[31:8]};
                    low_r <= {mag_r[7:0], 8'b0};
                    low_i <= {mag_i[7:0], 8'b0};
                    cnt <= '0;
                    if (den == '0) begin
                        {r_out, j_out, over_d} <= '0;
                        div0 <= 1'b1;
                        done <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem_r <= st_r[31:0];
                    rem_i <= st_i[31:0];
                    low_r <= low_r << 1;
                    low_i <= low_i << 1;
                    q_r <= {q_r[14:0], st_r[32]};
                    q_i <= {q_i[14:0], st_i[32]};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        r_out <= fin(ovr, sr, {q_r[14:0], st_r[32]});
                        j_out <= fin(ovi, si, {q_i[14:0], st_i[32]});
                        over_d <= ovr | ovi;
                        div0 <= 1'b0;
                        done <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign io.busy = busy;
    assign io.done = done;
    assign io.R = r_out;
    assign io.J = j_out;
    assign io.over_d = over_d;
    assign io.div0 = div0;
endmodule

// File: tb/tb_complex_div.sv
// tb_complex_div: randomized and directed checks of complex_div against an integer reference
module tb_complex_div;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int n_chk = 0;
    int n_fail = 0;
    complex_div_if io();
    complex_div dut (.clk(clk), .rstn(rstn), .io(io));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // Returns {over_d, div0, R, J} from exact integer arithmetic
    function automatic logic [33:0] model(input logic signed [15:0] a, b, c, d);
        longint n[2], den, mag, q;
        logic [15:0] res[2];
        logic ov;
        n[0] = longint'(a) * longint'(c) + longint'(b) * longint'(d);
        n[1] = longint'(b) * longint'(c) - longint'(a) * longint'(d);
        den = longint'(c) * longint'(c) + longint'(d) * longint'(d);
        if (den == 0) return {1'b0, 1'b1, 32'h0};
        ov = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mag = n[k] < 0 ? -n[k] : n[k];
            q = (mag * 256) / den;
            if (q >= 32768) begin
                ov = 1'b1;
                res[k] = n[k] < 0 ? 16'h8000 : 16'h7fff;
            end else begin
                res[k] = 16'(n[k] < 0 ? -q : q);
            end
        end
        return {ov, 1'b0, res[0], res[1]};
    endfunction
    task automatic run(input logic [15:0] a, b, c, d, input bit poke, output logic [15:0] r, j);
        logic [33:0] e;
        int n, extra;
        e = model(a, b, c, d);
        io.a = a; io.b = b; io.c = c; io.d = d;
        io.start = 1'b1;
        @(posedge clk); #1;
        io.start = 1'b0;
        io.a = 16'($urandom); io.b = 16'($urandom); io.c = 16'($urandom); io.d = 16'($urandom);
        chk("busy_on_accept", io.busy, 1);
        n = 0;
        do begin
            io.start = (poke && n == 8);
            @(posedge clk); #1;
            n++;
        end while (!io.done && n < 40);
        io.start = 1'b0;
        chk("latency", n + 1, e[32] ? 3 : 19);
        chk("R", io.R, e[31:16]);
        chk("J", io.J, e[15:0]);
        chk("over_d", io.over_d, e[33]);
        chk("div0", io.div0, e[32]);
        r = io.R;
        j = io.J;
        io.start = 1'b1;
        @(posedge clk); #1;
        io.start = 1'b0;
        chk("done_one_cycle", io.done, 0);
        chk("start_ignored_in_done", io.busy, 0);
        if (poke) begin
            extra = 0;
            repeat (25) begin
                @(posedge clk); #1;
                if (io.done) extra++;
            end
            chk("single_done", extra, 0);
        end
    endtask
    initial begin
        logic [15:0] r, j, c, d;
        int extra;
        io.start = 1'b0;
        {io.a, io.b, io.c, io.d} = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {io.R, io.J, io.done, io.busy, io.over_d, io.div0}, 0);
        rstn = 1'b1;
        run(16'h0100, 16'h0000, 16'h0100, 16'h0000, 0, r, j);
        chk("one_over_one_R", r, 16'h0100);
        run(16'h0100, 16'h0100, 16'h0100, 16'hff00, 0, r, j);
        chk("i_quotient_J", j, 16'h0100);
        run(16'hff00, 16'h0000, 16'h0300, 16'h0000, 0, r, j);
        chk("neg_third_R", r, 16'hffab);
        run(16'h0100, 16'h0000, 16'h0000, 16'h0000, 0, r, j);
        run(16'h7fff, 16'h0000, 16'h0001, 16'h0000, 0, r, j);
        chk("sat_pos_R", r, 16'h7fff);
        run(16'h8000, 16'h0000, 16'h0001, 16'h0000, 0, r, j);
        chk("sat_neg_R", r, 16'h8000);
        run(16'h0240, 16'hfe80, 16'h0120, 16'h00c0, 1, r, j);
        run(16'h0100, 16'h0000, 16'h0100, 16'h0000, 0, r, j);
        io.a = 16'h0500; io.b = 16'h0300; io.c = 16'h0200; io.d = 16'h0100;
        io.start = 1'b1;
        @(posedge clk); #1;
        io.start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rstn = 1'b0;
        @(posedge clk); #1;
        chk("reset_mid_div", {io.R, io.J, io.done, io.busy, io.over_d, io.div0}, 0);
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (io.done) extra++;
        end
        chk("no_done_after_abort", extra, 0);
        @(negedge clk);
        rstn = 1'b1;
        run(16'h0300, 16'h0100, 16'h0100, 16'h0100, 0, r, j);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: begin c = 16'($urandom); d = 16'($urandom); end
                1: begin c = 16'($signed($urandom_range(0, 8)) - 4); d = 16'($signed($urandom_range(0, 8)) - 4); end
                2: begin c = 16'h0000; d = 16'h0000; end
                default: begin c = 16'($signed($urandom_range(0, 4096)) - 2048); d = 16'($signed($urandom_range(0, 4096)) - 2048); end
            endcase
            run(16'($urandom), 16'($urandom), c, d, i % 8 == 3, r, j);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
